// File: rtl/logfbe_pkg.sv
// Shared constants for the log-filterbank-energy FIFO read path.
// Skid-buffer geometry, frame-counter width and frame-index sizing helper.
package logfbe_pkg;

    localparam int unsigned BUF_DEPTH         = 4;
    localparam int unsigned BUF_PTR_W         = 2;
    localparam int unsigned CREDIT_W          = BUF_PTR_W + 1;
    localparam int unsigned FRAME_CNT_W       = 16;
    localparam int unsigned FRAME_LEN_DEFAULT = 40;

    // Index width for a frame of frame_len words; never narrower than 1 bit.
    function automatic int unsigned frame_idx_w(input int unsigned frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/logfbe_rd_skid_buf.sv
// 4-entry circular skid buffer absorbing FIFO read latency.
// Write and read may happen in the same cycle; rd_data is the entry at the read pointer.
module logfbe_rd_skid_buf
    import logfbe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [BUF_PTR_W-1:0]  wr_ptr;
    logic [BUF_PTR_W-1:0]  rd_ptr;
    logic [CREDIT_W-1:0]   count;
    logic                  do_rd;

    assign valid   = (count != '0);
    assign do_rd   = rd_en & valid;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/logfbe_buff_reader.sv
// Read-side drain controller: credit-limited FIFO pops, skid buffer, framed valid/ready stream.
// Optional completed-frame counter port enabled by defining LOGFBE_RD_FRAME_CNT_EN.
module logfbe_buff_reader
    import logfbe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FRAME_LEN  = FRAME_LEN_DEFAULT
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   rd_go,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    output logic                   fifo_rd_en,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
`ifdef LOGFBE_RD_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam int unsigned IDX_W = frame_idx_w(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [CREDIT_W-1:0] credit;
    logic [IDX_W-1:0]    word_idx;
    logic                hs;
    logic                capture;

    assign hs       = out_valid & out_ready;
    assign out_last = (word_idx == LAST_IDX);

    // Credit counts buffered plus in-flight words, so a pop is allowed only if
    // the buffer is guaranteed a free slot when its data lands.
    always_comb begin
        fifo_rd_en = rd_go & ~fifo_empty & ((credit - CREDIT_W'(hs)) < CREDIT_W'(BUF_DEPTH));
    end

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign capture = fifo_rd_en;
        end else begin : g_latn
            logic [RD_LAT-1:0] infl_q;
            always_ff @(posedge rd_clk or posedge rd_rst) begin
                if (rd_rst) begin
                    infl_q <= '0;
                end else begin
                    infl_q <= RD_LAT'({infl_q, fifo_rd_en});
                end
            end
            assign capture = infl_q[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            credit   <= '0;
            word_idx <= '0;
        end else begin
            credit <= credit + CREDIT_W'(fifo_rd_en) - CREDIT_W'(hs);
            if (hs) begin
                word_idx <= out_last ? '0 : word_idx + 1'b1;
            end
        end
    end

`ifdef LOGFBE_RD_FRAME_CNT_EN
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            frame_cnt <= '0;
        end else if (hs & out_last) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

    logfbe_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .wr_en   (capture),
        .wr_data (fifo_rd_data),
        .rd_en   (hs),
        .rd_data (out_data),
        .valid   (out_valid)
    );

endmodule

// File: tb/tb_logfbe_buff_reader.sv
// Directed bench for logfbe_buff_reader at RD_LAT 0, 1 and 2 with a behavioural FIFO model.
// Frame-counter checks are compiled in when LOGFBE_RD_FRAME_CNT_EN is defined.
module tb_logfbe_buff_reader;

    localparam int unsigned FL = 40;

    logic rd_clk = 1'b0;
    logic rd_rst;
    always #5 rd_clk = ~rd_clk;

    logic [2:0]       go, ready, rd_en, empty, valid, last;
    logic [2:0][31:0] rdata, odata;
`ifdef LOGFBE_RD_FRAME_CNT_EN
    logic [2:0][15:0] fcnt;
`endif

    int unsigned avail  [3];
    int unsigned popped [3] = '{0, 0, 0};
    int unsigned exp_k  [3];
    int unsigned widx   [3];
    int unsigned hs_cnt [3] = '{0, 0, 0};
    logic        stall  [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] held   [3];
    logic [31:0] s2a, rd1_q, rd2_q;
    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [31:0] pat(input int unsigned i, input int unsigned k);
        return {8'(i), 8'h5A, 16'(k)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    logfbe_buff_reader #(.DATA_WIDTH(32), .RD_LAT(0), .FRAME_LEN(FL)) dut0 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_go(go[0]), .fifo_empty(empty[0]),
        .fifo_rd_data(rdata[0]), .fifo_rd_en(rd_en[0]), .out_data(odata[0]),
        .out_valid(valid[0]), .out_ready(ready[0]), .out_last(last[0])
`ifdef LOGFBE_RD_FRAME_CNT_EN
        , .frame_cnt(fcnt[0])
`endif
    );

    logfbe_buff_reader #(.DATA_WIDTH(32), .RD_LAT(1), .FRAME_LEN(FL)) dut1 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_go(go[1]), .fifo_empty(empty[1]),
        .fifo_rd_data(rdata[1]), .fifo_rd_en(rd_en[1]), .out_data(odata[1]),
        .out_valid(valid[1]), .out_ready(ready[1]), .out_last(last[1])
`ifdef LOGFBE_RD_FRAME_CNT_EN
        , .frame_cnt(fcnt[1])
`endif
    );

    logfbe_buff_reader #(.DATA_WIDTH(32), .RD_LAT(2), .FRAME_LEN(FL)) dut2 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_go(go[2]), .fifo_empty(empty[2]),
        .fifo_rd_data(rdata[2]), .fifo_rd_en(rd_en[2]), .out_data(odata[2]),
        .out_valid(valid[2]), .out_ready(ready[2]), .out_last(last[2])
`ifdef LOGFBE_RD_FRAME_CNT_EN
        , .frame_cnt(fcnt[2])
`endif
    );

    // FIFO model: word k of instance i is pat(i,k); non-popped cycles return junk.
    assign empty[0] = (popped[0] >= avail[0]);
    assign empty[1] = (popped[1] >= avail[1]);
    assign empty[2] = (popped[2] >= avail[2]);
    assign rdata[0] = rd_en[0] ? pat(0, popped[0]) : 32'hDEAD0000;
    assign rdata[1] = rd1_q;
    assign rdata[2] = rd2_q;

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            s2a   <= 32'hDEAD0002;
            rd1_q <= 32'hDEAD0001;
            rd2_q <= 32'hDEAD0002;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (rd_en[i]) popped[i] <= popped[i] + 1;
            end
            rd1_q <= rd_en[1] ? pat(1, popped[1]) : 32'hDEAD0001;
            s2a   <= rd_en[2] ? pat(2, popped[2]) : 32'hDEAD0002;
            rd2_q <= s2a;
        end
    end

    // Stream scoreboard: order, framing, stability under backpressure, credit bound.
    always @(negedge rd_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_rst) begin
                exp_k[i] = popped[i];
                widx[i]  = 0;
                stall[i] = 1'b0;
            end else begin
                if (stall[i]) begin
                    chk($sformatf("hold_valid[%0d]", i), 32'(valid[i]), 32'd1);
                    chk($sformatf("hold_data[%0d]", i), odata[i], held[i]);
                end
                if (valid[i] | rd_en[i])
                    chk($sformatf("outstanding_le4[%0d]", i), 32'((popped[i] - exp_k[i]) <= 4), 32'd1);
                if (valid[i]) begin
                    chk($sformatf("data[%0d]", i), odata[i], pat(i, exp_k[i]));
                    chk($sformatf("last[%0d]", i), 32'(last[i]), 32'(widx[i] == FL - 1));
                end
                stall[i] = valid[i] & ~ready[i];
                held[i]  = odata[i];
                if (valid[i] & ready[i]) begin
                    exp_k[i]++;
                    hs_cnt[i]++;
                    widx[i] = (widx[i] == FL - 1) ? 0 : widx[i] + 1;
                end
            end
        end
    end

    task automatic wait_hs(input int i, input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (hs_cnt[i] < target && n < budget) begin
            @(posedge rd_clk); #1;
            n++;
        end
        chk($sformatf("hs_count[%0d]", i), hs_cnt[i], target);
    endtask

    typedef struct {
        logic        go;
        logic        rdy;
        logic        exp_en;
        logic        exp_v;
        int unsigned k;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int unsigned p0, h0, n;

        // Startup then 10 cycles of backpressure on the RD_LAT=1 instance.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0};
        for (int r = 4; r < 12; r++) tbl[r] = '{1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 2};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 3};

        go = '0; ready = '0;
        for (int i = 0; i < 3; i++) avail[i] = 0;
        rd_rst = 1'b1;
        repeat (2) @(posedge rd_clk);
        #1;
        chk("rst_rd_en", 32'(rd_en[1]), 32'd0);
        chk("rst_valid", 32'(valid[1]), 32'd0);
        chk("rst_last", 32'(last[1]), 32'd0);
        chk("rst_data", odata[1], 32'd0);
`ifdef LOGFBE_RD_FRAME_CNT_EN
        chk("rst_frame_cnt", 32'(fcnt[1]), 32'd0);
`endif
        avail[1] = 40;

        for (int r = 0; r < 16; r++) begin
            @(posedge rd_clk); #1;
            if (r == 0) rd_rst = 1'b0;
            go[1]    = tbl[r].go;
            ready[1] = tbl[r].rdy;
            #2;
            chk($sformatf("tbl%0d_rd_en", r), 32'(rd_en[1]), 32'(tbl[r].exp_en));
            chk($sformatf("tbl%0d_valid", r), 32'(valid[1]), 32'(tbl[r].exp_v));
            chk($sformatf("tbl%0d_last", r), 32'(last[1]), 32'd0);
            if (tbl[r].exp_v) chk($sformatf("tbl%0d_data", r), odata[1], pat(1, tbl[r].k));
        end

        // Rest of frame 1, then drained.
        wait_hs(1, 40, 200);
        #2;
        chk("drained_valid", 32'(valid[1]), 32'd0);
        chk("drained_rd_en", 32'(rd_en[1]), 32'd0);
`ifdef LOGFBE_RD_FRAME_CNT_EN
        chk("frame_cnt_1", 32'(fcnt[1]), 32'd1);
`endif

        // FIFO runs dry after word 25 of frame 2, refilled 20 cycles later.
        avail[1] += 25;
        wait_hs(1, 65, 200);
        for (int c = 0; c < 20; c++) begin
            @(posedge rd_clk); #1;
            chk("gap_valid", 32'(valid[1]), 32'd0);
        end
        avail[1] += 18;
        wait_hs(1, 83, 200);
`ifdef LOGFBE_RD_FRAME_CNT_EN
        chk("frame_cnt_2", 32'(fcnt[1]), 32'd2);
`endif

        // Reset mid-frame with pops in flight.
        avail[1] += 10;
        repeat (3) begin @(posedge rd_clk); #1; end
        rd_rst   = 1'b1;
        avail[1] = popped[1];
        #1;
        chk("midrst_rd_en", 32'(rd_en[1]), 32'd0);
        chk("midrst_valid", 32'(valid[1]), 32'd0);
        chk("midrst_data", odata[1], 32'd0);
        chk("midrst_last", 32'(last[1]), 32'd0);
        @(posedge rd_clk); #1;
        chk("midrst_valid_edge", 32'(valid[1]), 32'd0);
`ifdef LOGFBE_RD_FRAME_CNT_EN
        chk("midrst_frame_cnt", 32'(fcnt[1]), 32'd0);
`endif
        rd_rst = 1'b0;
        h0 = hs_cnt[1];
        avail[1] += 40;
        wait_hs(1, h0 + 40, 200);
`ifdef LOGFBE_RD_FRAME_CNT_EN
        chk("frame_cnt_after_rst", 32'(fcnt[1]), 32'd1);
`endif
        go[1] = 1'b0;

        // RD_LAT=0 and RD_LAT=2: 100 words each under random ready.
        avail[0] += 100;
        avail[2] += 100;
        go[0] = 1'b1;
        go[2] = 1'b1;
        n = 0;
        while ((hs_cnt[0] < 100 || hs_cnt[2] < 100) && n < 1500) begin
            @(posedge rd_clk); #1;
            ready[0] = 1'($urandom_range(0, 1));
            ready[2] = 1'($urandom_range(0, 1));
            n++;
        end
        chk("rand_hs[0]", hs_cnt[0], 100);
        chk("rand_hs[2]", hs_cnt[2], 100);
        go[0] = 1'b0; go[2] = 1'b0;
        ready[0] = 1'b1; ready[2] = 1'b1;

        // rd_go dropped after two pops at RD_LAT=2.
        repeat (4) begin @(posedge rd_clk); #1; end
        avail[2] += 10;
        p0 = popped[2];
        h0 = hs_cnt[2];
        go[2] = 1'b1;
        #1 chk("go_c0_rd_en", 32'(rd_en[2]), 32'd1);
        @(posedge rd_clk); #2;
        chk("go_c1_rd_en", 32'(rd_en[2]), 32'd1);
        @(posedge rd_clk); #1;
        go[2] = 1'b0;
        #1 chk("go_off_rd_en", 32'(rd_en[2]), 32'd0);
        repeat (8) begin
            @(posedge rd_clk); #1;
            chk("go_off_hold_rd_en", 32'(rd_en[2]), 32'd0);
        end
        chk("go_off_pops", popped[2] - p0, 32'd2);
        chk("go_off_words", hs_cnt[2] - h0, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
